// File: rtl/stream_demux.sv
// Registered 1-to-NUM_OUT stream demultiplexer with a one-entry holding register per
// channel, all-or-nothing broadcast and a saturating counter of out-of-range drops.
module stream_demux #(
    parameter int DATA_W  = 64,
    parameter int NUM_OUT = 16,
    parameter int SEL_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1,
    parameter int CNT_W   = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        io_in_valid,
    output logic                        io_in_ready,
    input  logic [DATA_W-1:0]           io_in_data,
    input  logic [SEL_W-1:0]            io_in_select,
    input  logic                        io_in_bcast,
    output logic [NUM_OUT-1:0]          io_out_valid,
    input  logic [NUM_OUT-1:0]          io_out_ready,
    output logic [NUM_OUT*DATA_W-1:0]   io_out_data,
    output logic [CNT_W-1:0]            io_drop_count
);

    logic [NUM_OUT-1:0] full_r;
    logic [DATA_W-1:0]  data_r [NUM_OUT];
    logic [CNT_W-1:0]   drop_r;

    logic [NUM_OUT-1:0] free_s;
    logic [NUM_OUT-1:0] sel_hit_s;
    logic [NUM_OUT-1:0] load_s;
    logic               in_range_s;
    logic               ready_s;
    logic               accept_s;
    logic               drop_s;

    // Channel free/select decode, input ready and per-channel load strobes
    always_comb begin
        free_s    = ~full_r | io_out_ready;
        sel_hit_s = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            sel_hit_s[i] = (io_in_select == SEL_W'(i));
        end
        // An empty hit vector means the select points past the last channel
        in_range_s = |sel_hit_s;
        if (io_in_bcast) begin
            ready_s = &free_s;
        end else if (in_range_s) begin
            ready_s = |(sel_hit_s & free_s);
        end else begin
            ready_s = 1'b1;
        end
        accept_s = io_in_valid & ready_s & ~reset;
        if (io_in_bcast) begin
            load_s = {NUM_OUT{accept_s}};
        end else begin
            load_s = sel_hit_s & {NUM_OUT{accept_s}};
        end
        drop_s = accept_s & ~io_in_bcast & ~in_range_s;
    end

    // Full flags and the saturating drop counter
    always_ff @(posedge clock) begin
        if (reset) begin
            full_r <= '0;
            drop_r <= '0;
        end else begin
            full_r <= load_s | (full_r & ~io_out_ready);
            if (drop_s && !(&drop_r)) begin
                drop_r <= drop_r + CNT_W'(1);
            end
        end
    end

    // Holding registers change only on load; they carry no reset
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_OUT; i++) begin
            if (load_s[i]) begin
                data_r[i] <= io_in_data;
            end
        end
    end

    // Empty channels present all-zero data
    always_comb begin
        io_out_data = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (full_r[i]) begin
                io_out_data[i*DATA_W +: DATA_W] = data_r[i];
            end else begin
                io_out_data[i*DATA_W +: DATA_W] = '0;
            end
        end
    end

    assign io_in_ready   = ready_s;
    assign io_out_valid  = full_r;
    assign io_drop_count = drop_r;

endmodule
